// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and baud divider floor.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int unsigned UART_MIN_BAUD_DIV = 4;

endpackage

// File: rtl/wbit_fifo.sv
// First-word-fall-through FIFO; simultaneous push and pop are both honoured, even when full.
module wbit_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; contents are only observable once count says so.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised mid-bit sampling, start-glitch rejection, stop check, RX FIFO.
//   state | meaning
//   IDLE  | waiting for a low line while enabled
//   START | confirming the start bit at its middle
//   DATA  | sampling data bits LSB-first, one per bit period
//   STOP  | sampling the stop bit, then push / frame error / overrun
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rx_en_i,
    input  logic [15:0]           baud_div_i,
    input  logic                  rx_bit_i,
    input  logic                  rx_re_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  frame_err_o,
    output logic                  overrun_o
);

    localparam int BW = $clog2(DATA_WIDTH) + 1;

    rx_state_t             state;
    rx_state_t             state_nxt;
    logic                  sync1;
    logic                  rx_s;
    logic [15:0]           baud_cnt;
    logic [15:0]           baud_cnt_nxt;
    logic [BW-1:0]         bit_cnt;
    logic [BW-1:0]         bit_cnt_nxt;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic [15:0]           div;
    logic [15:0]           half;
    logic                  bit_end;
    logic                  half_end;
    logic                  pop;
    logic                  push;
    logic                  frame_err_nxt;
    logic                  overrun_nxt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx_bit_i;
            rx_s  <= sync1;
        end
    end

    // Out-of-range dividers are floored so the half-bit compare never underflows.
    assign div      = (baud_div_i < 16'(UART_MIN_BAUD_DIV)) ? 16'(UART_MIN_BAUD_DIV) : baud_div_i;
    assign half     = div >> 1;
    assign bit_end  = (baud_cnt == div - 16'd1);
    assign half_end = (baud_cnt == half - 16'd1);
    assign pop      = rx_re_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            state       <= state_nxt;
            baud_cnt    <= baud_cnt_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shift       <= shift_nxt;
            frame_err_o <= frame_err_nxt;
            overrun_o   <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        baud_cnt_nxt  = baud_cnt + 16'd1;
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift;
        push          = 1'b0;
        frame_err_nxt = 1'b0;
        overrun_nxt   = 1'b0;
        if (!rx_en_i) begin
            state_nxt    = IDLE;
            baud_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt_nxt = '0;
                    if (!rx_s) state_nxt = START;
                end
                START: begin
                    if (half_end) begin
                        baud_cnt_nxt = '0;
                        bit_cnt_nxt  = '0;
                        state_nxt    = rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt_nxt = '0;
                        shift_nxt    = {rx_s, shift[DATA_WIDTH-1:1]};
                        bit_cnt_nxt  = bit_cnt + 1'b1;
                        if (bit_cnt == BW'(DATA_WIDTH - 1)) state_nxt = STOP;
                    end
                end
                STOP: begin
                    // Leaving at the stop sample lets a back-to-back start edge be seen.
                    if (bit_end) begin
                        baud_cnt_nxt = '0;
                        state_nxt    = IDLE;
                        if (!rx_s)                 frame_err_nxt = 1'b1;
                        else if (!full_o || pop)   push          = 1'b1;
                        else                       overrun_nxt   = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    wbit_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) rx_buffer (
        .clk     (clk_i),
        .rst     (!rst_ni),
        .wr_en   (push),
        .wr_data (shift_nxt),
        .rd_en   (pop),
        .rd_data (dout_o),
        .full    (full_o),
        .empty   (empty_o)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are modelled into an expected-byte queue and error counters,
// a monitor pops the FIFO and counts error pulses independently of the stimulus.
module tb_uart_rx;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_en = 1'b0;
    logic [15:0] baud_div = 16'd16;
    logic        rx_bit = 1'b1;
    logic        re_auto = 1'b0;
    logic        re_manual = 1'b0;
    logic        rx_re;
    logic [7:0]  dout;
    logic        full;
    logic        empty;
    logic        frame_err;
    logic        overrun;

    assign rx_re = re_auto | re_manual;

    uart_rx #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rx_en_i     (rx_en),
        .baud_div_i  (baud_div),
        .rx_bit_i    (rx_bit),
        .rx_re_i     (rx_re),
        .dout_o      (dout),
        .full_o      (full),
        .empty_o     (empty),
        .frame_err_o (frame_err),
        .overrun_o   (overrun)
    );

    always #5 clk = ~clk;

    int         checks_total  = 0;
    int         checks_passed = 0;
    logic [7:0] exp_q[$];
    int         exp_ferr = 0;
    int         exp_ovr  = 0;
    int         seen_ferr = 0;
    int         seen_ovr  = 0;
    bit         auto_read = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks_total++;
        if (act == req) checks_passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Monitor: counts error pulses and, when enabled, pops and scores every presented byte.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (frame_err) seen_ferr++;
            if (overrun)   seen_ovr++;
        end
        if (auto_read && rst_n && !empty) begin
            if (exp_q.size() == 0) begin
                checks_total++;
                $display("FAIL unexpected_byte: got 0x%02h, required no byte", dout);
            end else begin
                check("rx_data", int'(dout), int'(exp_q.pop_front()));
            end
            re_auto = 1'b1;
        end else begin
            re_auto = 1'b0;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // Clock edges from the edge before the start bit to the stop-bit sample.
    function automatic int stop_edge(input int div);
        return 3 + div / 2 + 9 * div;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: what one complete frame does to the FIFO and flags.
    task automatic model_frame(input logic [7:0] data, input bit stop_ok, input bit with_pop);
        int occ;
        occ = exp_q.size() - (with_pop ? 1 : 0);
        if (!stop_ok)          exp_ferr++;
        else if (occ >= DEPTH) exp_ovr++;
        else                   exp_q.push_back(data);
    endtask

    task automatic drive_frame(input logic [7:0] data, input bit stop_ok);
        logic [9:0] bits;
        bits = {stop_ok, data, 1'b0};
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            rx_bit = bits[i];
            repeat (int'(baud_div)) @(posedge clk);
            #1;
        end
        rx_bit = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input bit stop_ok);
        model_frame(data, stop_ok, 1'b0);
        drive_frame(data, stop_ok);
    endtask

    task automatic check_flags(input string name);
        check({name, "_frame_err_count"}, seen_ferr, exp_ferr);
        check({name, "_overrun_count"}, seen_ovr, exp_ovr);
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 3000;
        auto_read = 1'b1;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        idle(4);
        auto_read = 1'b0;
        idle(2);
        check({name, "_pending"}, exp_q.size(), 0);
        check({name, "_empty"}, int'(empty), 1);
    endtask

    initial begin
        logic [7:0] b;
        bit         ok;
        int         d;

        #1;
        check("reset_empty", int'(empty), 1);
        check("reset_full", int'(full), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_overrun", int'(overrun), 0);
        #22 rst_n = 1'b1;
        rx_en = 1'b1;
        idle(4);

        // 1: single good frame, arrival timing
        fork
            send_frame(8'hA5, 1'b1);
            begin
                @(posedge clk);
                repeat (stop_edge(16) - 1) @(posedge clk);
                #1 check("t1_empty_before_stop", int'(empty), 1);
                @(posedge clk);
                #1 check("t1_empty_after_stop", int'(empty), 0);
                check("t1_dout", int'(dout), 8'hA5);
            end
        join
        idle(20);
        drain("t1");
        check_flags("t1");

        // 2: start glitch
        @(posedge clk);
        #1 rx_bit = 1'b0;
        idle(3);
        rx_bit = 1'b1;
        idle(40);
        check("t2_empty", int'(empty), 1);
        check_flags("t2");

        // 3: frame error, then a good frame
        send_frame(8'h3C, 1'b0);
        idle(40);
        check("t3_empty_after_ferr", int'(empty), 1);
        check_flags("t3a");
        send_frame(8'h81, 1'b1);
        idle(20);
        drain("t3");
        check_flags("t3b");

        // 4: fill to full, overrun on the 17th, drain in order
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1);
            if (i == 15) begin
                idle(20);
                check("t4_full_after_16", int'(full), 1);
            end
        end
        idle(20);
        check("t4_full_after_17", int'(full), 1);
        check_flags("t4");
        drain("t4");
        check("t4_full_after_drain", int'(full), 0);

        // 5: back-to-back frames at a slow baud
        baud_div = 16'd104;
        idle(4);
        auto_read = 1'b1;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        idle(120);
        drain("t5");
        check_flags("t5");

        // 5b: pop and push on the same edge while full
        baud_div = 16'd16;
        idle(4);
        for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom_range(255, 0)), 1'b1);
        idle(20);
        check("t5b_full", int'(full), 1);
        b = 8'($urandom_range(255, 0));
        model_frame(b, 1'b1, 1'b1);
        fork
            drive_frame(b, 1'b1);
            begin
                @(posedge clk);
                repeat (stop_edge(16) - 1) @(posedge clk);
                #1 check("t5b_head", int'(dout), int'(exp_q.pop_front()));
                re_manual = 1'b1;
                @(posedge clk);
                #1 re_manual = 1'b0;
                check("t5b_full_at_pop_push", int'(full), 1);
            end
        join
        idle(20);
        check("t5b_full_after", int'(full), 1);
        check_flags("t5b");
        drain("t5b");

        // 6: reset mid-frame, recovery, rx_en drop mid-frame
        send_frame(8'h77, 1'b1);
        idle(20);
        check("t6_prefill_empty", int'(empty), 0);
        fork
            drive_frame(8'hC3, 1'b1);
            begin
                @(posedge clk);
                repeat (60) @(posedge clk);
                #3 rst_n = 1'b0;
                #1 check("t6_rst_empty", int'(empty), 1);
                check("t6_rst_full", int'(full), 0);
                check("t6_rst_frame_err", int'(frame_err), 0);
                check("t6_rst_overrun", int'(overrun), 0);
            end
        join
        exp_q.delete();
        idle(4);
        rst_n = 1'b1;
        idle(4);
        send_frame(8'h5A, 1'b1);
        idle(20);
        drain("t6a");
        auto_read = 1'b1;
        fork
            drive_frame(8'hE7, 1'b1);
            begin
                @(posedge clk);
                repeat (50) @(posedge clk);
                #1 rx_en = 1'b0;
            end
        join
        rx_en = 1'b1;
        idle(60);
        drain("t6b");
        check_flags("t6");

        // Randomised frames, baud and stop bits
        auto_read = 1'b1;
        for (int n = 0; n < 40; n++) begin
            d  = int'($urandom_range(24, 4));
            baud_div = 16'(d);
            idle(2);
            b  = 8'($urandom_range(255, 0));
            ok = ($urandom_range(7, 0) != 0);
            send_frame(b, ok);
            idle(2 * d + 4);
        end
        idle(20);
        drain("rand");
        check_flags("rand");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
